// File: rtl/song_pkg.sv
// Shared types, widths and ROM word helpers for the song sequencer.
package song_pkg;

  localparam int NOTE_W         = 6;
  localparam int DUR_W          = 6;
  localparam int IDX_W          = 5;
  localparam int SONG_W         = 2;
  localparam int ADDR_W         = SONG_W + IDX_W;
  localparam int ROM_W          = NOTE_W + DUR_W;
  localparam int NOTES_PER_SONG = 32;

  // A zero duration in a ROM word marks the end of a song.
  localparam logic [DUR_W-1:0] END_DUR = 6'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_LOAD,
    ST_PLAY,
    ST_PAUSED
  } state_e;

  // ROM word layout is {note, duration}.
  function automatic logic [NOTE_W-1:0] rom_note(input logic [ROM_W-1:0] word);
    return word[ROM_W-1:DUR_W];
  endfunction

  function automatic logic [DUR_W-1:0] rom_dur(input logic [ROM_W-1:0] word);
    return word[DUR_W-1:0];
  endfunction

endpackage

// File: rtl/note_timer.sv
// Beat counter for the note currently sounding; flags the beat that ends it.
module note_timer
  import song_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             enable,
  input  logic             beat,
  input  logic [DUR_W-1:0] dur_in,
  output logic             expire
);

  logic [DUR_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [DUR_W-1:0] dur_q, dur_d;

  // Load restarts the count for a new entry; otherwise count beats only while enabled.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    dur_d      = dur_q;
    if (load) begin
      beat_cnt_d = '0;
      dur_d      = dur_in;
    end else if (enable && beat) begin
      beat_cnt_d = beat_cnt_q + DUR_W'(1);
    end
  end

  // Counter and duration registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt_q <= '0;
      dur_q      <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      dur_q      <= dur_d;
    end
  end

  // The last beat of the note is the one that lands on count dur-1.
  always_comb begin
    expire = enable && beat && (beat_cnt_q == (dur_q - DUR_W'(1)));
  end

endmodule

// File: rtl/song_sequencer.sv
// Walks one song of the song ROM, timing each entry in beats and presenting
// the current note to the player; handles pause, song change and end marker.
module song_sequencer
  import song_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              play,
  input  logic [SONG_W-1:0] song_sel,
  input  logic              beat,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [ROM_W-1:0]  rom_dout,
  output logic [NOTE_W-1:0] note,
  output logic              note_valid,
  output logic              new_note,
  output logic              song_done,
  output logic              playing,
  output logic [IDX_W-1:0]  note_idx
);

  state_e            state_q, state_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              new_note_q, new_note_d;
  logic              song_done_q, song_done_d;
  logic              done_hold_q, done_hold_d;
  logic              pending_q, pending_d;
  logic              set_hold;

  logic              sel_change;
  logic              is_end_word;
  logic              timer_load;
  logic              timer_en;
  logic              timer_expire;

  // A song change restarts the fetch from any non-idle state and overrides everything else.
  assign sel_change  = (state_q != ST_IDLE) && (song_sel != song_q);
  assign is_end_word = (rom_dur(rom_dout) == END_DUR);
  assign timer_load  = (state_q == ST_LOAD) && !sel_change && !is_end_word;
  assign timer_en    = (state_q == ST_PLAY) && !sel_change && play;

  note_timer u_note_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (timer_load),
    .enable  (timer_en),
    .beat    (beat),
    .dur_in  (rom_dur(rom_dout)),
    .expire  (timer_expire)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      song_q      <= '0;
      idx_q       <= '0;
      note_q      <= '0;
      rom_addr_q  <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
      done_hold_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      song_q      <= song_d;
      idx_q       <= idx_d;
      note_q      <= note_d;
      rom_addr_q  <= rom_addr_d;
      new_note_q  <= new_note_d;
      song_done_q <= song_done_d;
      done_hold_q <= done_hold_d;
      pending_q   <= pending_d;
    end
  end

  // Next state plus the entry bookkeeping that moves with each transition.
  always_comb begin
    state_d     = state_q;
    song_d      = song_q;
    idx_d       = idx_q;
    note_d      = note_q;
    new_note_d  = 1'b0;
    song_done_d = 1'b0;
    pending_d   = pending_q;
    set_hold    = 1'b0;

    if (sel_change) begin
      state_d   = ST_FETCH;
      song_d    = song_sel;
      idx_d     = '0;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (play && !done_hold_q) begin
            state_d = ST_FETCH;
            song_d  = song_sel;
            idx_d   = '0;
          end
        end
        ST_FETCH: state_d = ST_WAIT;
        ST_WAIT:  state_d = ST_LOAD;
        ST_LOAD: begin
          if (is_end_word) begin
            state_d     = ST_IDLE;
            song_done_d = 1'b1;
            set_hold    = 1'b1;
          end else begin
            note_d = rom_note(rom_dout);
            if (play) begin
              state_d    = ST_PLAY;
              new_note_d = 1'b1;
              pending_d  = 1'b0;
            end else begin
              state_d   = ST_PAUSED;
              pending_d = 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (!play) begin
            state_d = ST_PAUSED;
          end else if (timer_expire) begin
            if (idx_q == IDX_W'(NOTES_PER_SONG - 1)) begin
              state_d     = ST_IDLE;
              song_done_d = 1'b1;
              set_hold    = 1'b1;
            end else begin
              state_d = ST_FETCH;
              idx_d   = idx_q + IDX_W'(1);
            end
          end
        end
        ST_PAUSED: begin
          if (play) begin
            state_d    = ST_PLAY;
            new_note_d = pending_q;
            pending_d  = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    done_hold_d = play ? (done_hold_q | set_hold) : 1'b0;
    rom_addr_d  = (state_d == ST_FETCH) ? {song_d, idx_d} : rom_addr_q;
  end

  // Output decode from the registered state.
  always_comb begin
    rom_addr   = rom_addr_q;
    note       = note_q;
    note_valid = (state_q == ST_PLAY);
    new_note   = new_note_q;
    song_done  = song_done_q;
    playing    = (state_q != ST_IDLE);
    note_idx   = idx_q;
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer with a synchronous ROM model and an
// entry-level reference model (fetch gap countdown, beats-left countdown).
module tb_song_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        play;
  logic [1:0]  song_sel;
  logic        beat;
  logic [6:0]  rom_addr;
  logic [11:0] rom_dout;
  logic [5:0]  note;
  logic        note_valid;
  logic        new_note;
  logic        song_done;
  logic        playing;
  logic [4:0]  note_idx;

  logic [11:0] rom [128];

  int errCount   = 0;
  int checkCount = 0;

  // Reference model state
  bit mActive, mSounding, mPending, mHold, mDone, mNew;
  int mGap, mLeft, mSong, mIdx, mAddr, mNote;

  song_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .play       (play),
    .song_sel   (song_sel),
    .beat       (beat),
    .rom_addr   (rom_addr),
    .rom_dout   (rom_dout),
    .note       (note),
    .note_valid (note_valid),
    .new_note   (new_note),
    .song_done  (song_done),
    .playing    (playing),
    .note_idx   (note_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_dout <= rom[rom_addr];

  task automatic checkOutput(input string tag, input int got, input int exp);
    checkCount++;
    if (got != exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mActive = 0; mSounding = 0; mPending = 0; mHold = 0; mDone = 0; mNew = 0;
    mGap = 0; mLeft = 0; mSong = 0; mIdx = 0; mAddr = 0; mNote = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs present at the edge.
  task automatic modelStep();
    logic [11:0] w;
    mDone = 0;
    mNew  = 0;
    if (!reset_n) return;
    if (!mActive) begin
      if (play && !mHold) begin
        mActive = 1; mSong = int'(song_sel); mIdx = 0; mGap = 3;
        mSounding = 0; mAddr = mSong * 32;
      end
    end else if (int'(song_sel) != mSong) begin
      mSong = int'(song_sel); mIdx = 0; mGap = 3; mPending = 0;
      mSounding = 0; mAddr = mSong * 32;
    end else if (mGap > 1) begin
      mGap--;
    end else if (mGap == 1) begin
      w = rom[mSong * 32 + mIdx];
      mGap = 0;
      if (w[5:0] == 6'd0) begin
        mActive = 0; mDone = 1; mHold = 1; mSounding = 0;
      end else begin
        mNote = int'(w[11:6]);
        mLeft = int'(w[5:0]);
        if (play) begin
          mSounding = 1; mNew = 1; mPending = 0;
        end else begin
          mSounding = 0; mPending = 1;
        end
      end
    end else if (mSounding) begin
      if (!play) begin
        mSounding = 0;
      end else if (beat) begin
        mLeft--;
        if (mLeft == 0) begin
          mSounding = 0;
          if (mIdx == 31) begin
            mActive = 0; mDone = 1; mHold = 1;
          end else begin
            mIdx++; mGap = 3; mAddr = mSong * 32 + mIdx;
          end
        end
      end
    end else if (play) begin
      mSounding = 1;
      if (mPending) mNew = 1;
      mPending = 0;
    end
    if (!play) mHold = 0;
  endtask

  task automatic compareAll();
    checkOutput("rom_addr",   int'(rom_addr),   mAddr);
    checkOutput("note",       int'(note),       mNote);
    checkOutput("note_valid", int'(note_valid), int'(mActive && mGap == 0 && mSounding));
    checkOutput("new_note",   int'(new_note),   int'(mNew));
    checkOutput("song_done",  int'(song_done),  int'(mDone));
    checkOutput("playing",    int'(playing),    int'(mActive));
    checkOutput("note_idx",   int'(note_idx),   mIdx);
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    compareAll();
  endtask

  task automatic applyStimulus(input logic p, input logic [1:0] s, input logic b);
    play     = p;
    song_sel = s;
    beat     = b;
    tick();
  endtask

  // Asynchronous reset asserted mid-cycle, held across two edges.
  task automatic doReset();
    reset_n  = 1'b0;
    play     = 1'b0;
    song_sel = 2'd0;
    beat     = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_rom_addr",   int'(rom_addr),   0);
    checkOutput("rst_note",       int'(note),       0);
    checkOutput("rst_note_valid", int'(note_valid), 0);
    checkOutput("rst_new_note",   int'(new_note),   0);
    checkOutput("rst_song_done",  int'(song_done),  0);
    checkOutput("rst_playing",    int'(playing),    0);
    checkOutput("rst_note_idx",   int'(note_idx),   0);
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int cnt, nn, maxIdx;
    bit b, done, p;
    logic [1:0] s;

    for (int i = 0; i < 128; i++) begin
      rom[i] = {6'($urandom_range(63, 0)), 6'($urandom_range(4, 1))};
      if ((i >= 42 && i < 64) || (i >= 74 && i < 96))
        if ($urandom_range(11, 0) == 0) rom[i][5:0] = 6'd0;
    end
    rom[28] = {6'd37, 6'd0};
    rom[32] = {6'd35, 6'd36};
    rom[33] = {6'd20, 6'd18};
    rom[64] = {6'd43, 6'd3};

    doReset();

    // Start song 1: first entry is 36 beats long.
    applyStimulus(1, 1, 0);
    checkOutput("start_addr", int'(rom_addr), 32);
    checkOutput("start_playing", int'(playing), 1);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    checkOutput("first_new_note", int'(new_note), 1);
    checkOutput("first_note", int'(note), 35);
    checkOutput("first_valid", int'(note_valid), 1);
    cnt = 0;
    for (int i = 0; i < 400 && note_valid; i++) begin
      b = (i % 2 == 1);
      if (note_valid && b) cnt++;
      applyStimulus(1, 1, b);
    end
    checkOutput("beats_note0", cnt, 36);
    checkOutput("next_addr", int'(rom_addr), 33);

    // Entry of 18 beats: 10 beats, pause over 5 beats, resume for the rest.
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    checkOutput("second_new_note", int'(new_note), 1);
    checkOutput("second_note", int'(note), 20);
    cnt = 0;
    for (int i = 0; i < 100 && cnt < 10; i++) begin
      b = (i % 2 == 1);
      if (note_valid && b) cnt++;
      applyStimulus(1, 1, b);
    end
    applyStimulus(0, 1, 0);
    checkOutput("pause_valid", int'(note_valid), 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, (i % 2 == 1));
    checkOutput("paused_valid", int'(note_valid), 0);
    applyStimulus(1, 1, 0);
    checkOutput("resume_valid", int'(note_valid), 1);
    checkOutput("resume_no_new", int'(new_note), 0);
    cnt = 0;
    nn  = 0;
    for (int i = 0; i < 200 && note_valid; i++) begin
      b = (i % 2 == 1);
      if (note_valid && b) cnt++;
      applyStimulus(1, 1, b);
      if (new_note) nn++;
    end
    checkOutput("resume_beats", cnt, 8);
    checkOutput("resume_new_count", nn, 0);

    // Song change from song 1 idx 7 to song 2.
    for (int i = 0; i < 1000 && !(note_idx == 5'd7 && note_valid); i++)
      applyStimulus(1, 1, (i % 2 == 1));
    checkOutput("reach_idx7", int'(note_idx), 7);
    applyStimulus(1, 2, 0);
    checkOutput("change_addr", int'(rom_addr), 64);
    applyStimulus(1, 2, 0);
    applyStimulus(1, 2, 0);
    applyStimulus(1, 2, 0);
    checkOutput("change_new_note", int'(new_note), 1);
    checkOutput("change_note", int'(note), 43);

    // Reset mid-PLAY, then song 0 up to its end marker at idx 28.
    doReset();
    applyStimulus(1, 0, 0);
    checkOutput("post_reset_addr", int'(rom_addr), 0);
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      applyStimulus(1, 0, (i % 2 == 1));
      if (song_done) done = 1;
    end
    checkOutput("song0_done", int'(done), 1);
    checkOutput("song0_end_idx", int'(note_idx), 28);
    checkOutput("song0_idle", int'(playing), 0);
    for (int i = 0; i < 20; i++) applyStimulus(1, 0, (i % 2 == 1));
    checkOutput("hold_idle", int'(playing), 0);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("restart_playing", int'(playing), 1);

    // Switch to song 3 (no end marker) and play it through all 32 entries.
    applyStimulus(1, 3, 0);
    checkOutput("song3_addr", int'(rom_addr), 96);
    done   = 0;
    maxIdx = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      applyStimulus(1, 3, (i % 2 == 1));
      if (int'(note_idx) > maxIdx) maxIdx = int'(note_idx);
      if (song_done) done = 1;
    end
    checkOutput("song3_done", int'(done), 1);
    checkOutput("song3_max_idx", maxIdx, 31);

    // Randomized play/pause, song changes, beats and occasional resets.
    p = 1;
    s = 2'd3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19, 0) == 0) p = ~p;
      if ($urandom_range(99, 0) == 0) s = 2'($urandom_range(3, 0));
      if ($urandom_range(499, 0) == 0) begin
        doReset();
        p = 0;
        s = 2'd0;
      end
      applyStimulus(p, s, ($urandom_range(9, 0) < 4));
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
